// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the MSB-first hold arbiter.
package prio_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [4:0] msb_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_arbiter_msb_to_lsb_hold_pick.sv
// Combinational winner selection: highest-index bit of vec not masked by excl.
module prio_pick_msb #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] vec,
    input  logic [SIZE-1:0] excl,
    output logic [SIZE-1:0] onehot,
    output logic            valid
);

    logic [SIZE-1:0] masked;

    always_comb begin
        masked = vec & ~excl;
        onehot = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (masked[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
        valid = |masked;
    end

endmodule

// File: rtl/prio_arbiter_msb_to_lsb_hold.sv
// Fixed-priority (MSB highest) arbiter that holds a grant until done, abort or hold-limit timeout.
module prio_arbiter_msb_to_lsb_hold
    import prio_arb_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] req,
    input  logic            done,
    output logic [SIZE-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);

    arb_state_e      state_q, state_d;
    logic [SIZE-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [SIZE-1:0] pick_excl;
    logic [SIZE-1:0] pick_onehot;
    logic            pick_valid;
    logic            granted_req;
    logic [31:0]     gnt_vec;

    // In HOLD the current holder is always excluded; arbitration only matters there on done/timeout.
    assign pick_excl   = (state_q == HOLD) ? gnt_q : '0;
    assign granted_req = |(req & gnt_q);

    prio_pick_msb #(
        .SIZE (SIZE)
    ) u_pick (
        .vec    (req),
        .excl   (pick_excl),
        .onehot (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        gnt_vec   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    cnt_d   = CW'(1);
                    state_d = HOLD;
                end else begin
                    gnt_d = '0;
                    cnt_d = '0;
                end
            end
            HOLD: begin
                // done outranks a simultaneous request drop; an abort never re-arbitrates.
                if (done || (granted_req && cnt_q == HOLD_MAX)) begin
                    timeout_d = ~done;
                    if (pick_valid) begin
                        gnt_d = pick_onehot;
                        cnt_d = CW'(1);
                    end else begin
                        gnt_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (!granted_req) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        gnt_vec  = 32'(gnt_d);
        gnt_id_d = IDW'(msb_index(gnt_vec));
        busy_d   = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_msb_to_lsb_hold.sv
// Directed, table-driven bench for the MSB-first hold arbiter (SIZE=4, MAX_HOLD=4).
module tb_prio_arbiter_msb_to_lsb_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[14];

    prio_arbiter_msb_to_lsb_hold #(
        .SIZE     (4),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] expG, input logic [1:0] expId,
                               input logic expB, input logic expT);
        checks++;
        if (gnt !== expG || gnt_id !== expId || busy !== expB || timeout !== expT) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
                     name, gnt, gnt_id, busy, timeout, expG, expId, expB, expT);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // req, done -> expected gnt, gnt_id, busy, timeout after the next edge
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b1101, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].req, vecs[i].done);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to);
        end

        // Hold limit: bit1 kept four cycles, then revoked with a timeout pulse in favour of bit0.
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(4'b0011, 1'b0);
            checkOutput($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        applyStimulus(4'b0011, 1'b0);
        checkOutput("timeout_pulse", 4'b0001, 2'd0, 1'b1, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("timeout_clear", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges while bit0 is held.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req  = 4'b0001;
        done = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("post_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_msb_to_lsb_hold.md
PRIO_ARBITER_MSB_TO_LSB_HOLD -- requirements
Module: prio_arbiter_msb_to_lsb_hold

Interface
- REQ-001: Parameter SIZE, default 4: number of requesters; legal range 1..32.
- REQ-002: Parameter MAX_HOLD, default 16: maximum number of cycles a grant may be held; legal range 2..65535.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: req  input  SIZE  per-requester request level; bit SIZE-1 has the highest priority, bit 0 the lowest.
- REQ-006: done  input  1  granted requester finishes its transaction this cycle.
- REQ-007: gnt  output  SIZE  registered one-hot (or zero) grant.
- REQ-008: gnt_id  output  max(1,$clog2(SIZE))  binary index of the granted bit; 0 when gnt is zero.
- REQ-009: busy  output  1  high while any grant is held.
- REQ-010: timeout  output  1  single-cycle pulse when a grant is forcibly revoked by the hold limit.

Function
- REQ-011: The FSM SHALL have two states: IDLE (no grant) and HOLD (grant held).
- REQ-012: In IDLE with |req high, the block SHALL load gnt with the highest-index set req bit and enter HOLD at the next edge (1-cycle request-to-grant latency).
- REQ-013: In IDLE with req == 0, gnt SHALL remain 0; done SHALL be ignored in IDLE.
- REQ-014: In HOLD, gnt SHALL remain constant regardless of higher-priority requests (no preemption).
- REQ-015: In HOLD with done high, the block SHALL re-arbitrate at that edge among req bits, excluding the currently granted bit.
  - Winner found: gnt switches to the winner with no idle bubble, and the hold counter resets.
  - No winner: gnt clears and the FSM returns to IDLE.
- REQ-016: In HOLD, if the granted req bit drops while done is low, gnt SHALL clear and the FSM SHALL return to IDLE at the next edge (abort, no re-arbitration that cycle).
- REQ-017: If done and a drop of the granted req bit coincide, the event SHALL be treated as done (REQ-015).
- REQ-018: A hold counter SHALL count cycles in HOLD, starting at 1 on the grant cycle.
  - When it reaches MAX_HOLD with done low: timeout pulses for exactly one cycle, aligned with gnt clearing.
  - In that case, re-arbitration follows REQ-015 (excluding the revoked bit).
- REQ-019: The hold counter SHALL saturate and never wrap; its width is $clog2(MAX_HOLD+1).
- REQ-020: gnt_id and busy SHALL be registered, consistent with gnt in the same cycle, and busy == |gnt.
- REQ-021: With SIZE == 1, exclusion on done SHALL yield an IDLE return; a still-high req is regranted one cycle later.

Reset
- REQ-022: While rst_n is low, the following SHALL be forced immediately and asynchronously, independent of clk:
  - gnt = 0, gnt_id = 0, busy = 0, timeout = 0
  - FSM = IDLE, hold counter = 0
- REQ-023: Reset asserted mid-HOLD SHALL drop the grant immediately; after deassertion, the first arbitration SHALL follow REQ-012.

Structure
- REQ-024: The state enum (IDLE, HOLD) SHALL reside in the shared package prio_arb_pkg.
- REQ-025: The package SHALL also define a function returning the highest set bit index of a vector.
- REQ-026: Winner selection SHALL be a combinational sub-module prio_pick_msb (inputs: vector, exclude mask; outputs: one-hot, valid), instantiated once.

Verification
- REQ-027: Basic priority: req=4'b0101 from IDLE -> cycle+1 gnt=4'b0100, gnt_id=2, busy=1.
- REQ-028: No preemption: hold gnt=4'b0001, then raise req[3] -> gnt stays 4'b0001; done=1 -> next cycle gnt=4'b1000 with no bubble.
- REQ-029: Exclusion: gnt=4'b1000, req=4'b1010, done=1 -> next gnt=4'b0010, even though req[3] is still high.
- REQ-030: Abort: gnt=4'b0100, drop req[2] with done=0 -> next cycle gnt=0, busy=0, timeout=0.
- REQ-031: Timeout: MAX_HOLD=4, req=4'b0011 held, done never asserted -> gnt=4'b0010 for 4 cycles, then timeout=1 for one cycle with gnt=4'b0001.
- REQ-032: Async reset: assert rst_n=0 mid-HOLD between clock edges -> gnt=0 and busy=0 before the next edge; after release with req=4'b0001 -> grant one cycle later.
